// File: rtl/vfu_mbus_arb.sv
// Round-robin merge of NUM_CH single-beat requesters onto one AXI-style mbus port.
// Per-direction order FIFOs steer each r beat / b response back to its issuing channel.
module vfu_mbus_arb #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int OUTSTANDING = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              ch_req_valid,
    output logic [NUM_CH-1:0]              ch_req_ready,
    input  logic [NUM_CH-1:0]              ch_req_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_req_wdata,
    input  logic [NUM_CH*DATA_WIDTH/8-1:0] ch_req_strb,
    output logic [NUM_CH-1:0]              ch_rd_valid,
    output logic [DATA_WIDTH-1:0]          ch_rd_data,
    output logic [NUM_CH-1:0]              ch_wr_done,
    output logic                           ch_wr_err,
    output logic [ADDR_WIDTH-1:0]          mbus_ar_addr,
    output logic                           mbus_ar_valid,
    input  logic                           mbus_ar_ready,
    input  logic [DATA_WIDTH-1:0]          mbus_r_data,
    input  logic                           mbus_r_valid,
    output logic                           mbus_r_ready,
    output logic [ADDR_WIDTH-1:0]          mbus_aw_addr,
    output logic                           mbus_aw_valid,
    input  logic                           mbus_aw_ready,
    output logic [DATA_WIDTH-1:0]          mbus_w_data,
    output logic [DATA_WIDTH/8-1:0]        mbus_w_strb,
    output logic                           mbus_w_valid,
    input  logic                           mbus_w_ready,
    input  logic [1:0]                     mbus_b_resp,
    input  logic                           mbus_b_valid,
    output logic                           mbus_b_ready,
    output logic                           protocol_err
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = $clog2(NUM_CH);
    localparam int PW = $clog2(OUTSTANDING);
    localparam logic [CW:0] NCH = (CW+1)'(NUM_CH);

    logic [CW-1:0]         rr_q, rr_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  aw_valid_q, aw_valid_d;
    logic                  w_valid_q, w_valid_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [SW-1:0]         w_strb_q, w_strb_d;
    logic                  perr_q, perr_d;

    logic [CW-1:0] rd_ids_q [OUTSTANDING];
    logic [CW-1:0] wr_ids_q [OUTSTANDING];
    logic [PW-1:0] rd_wp_q, rd_rp_q, wr_wp_q, wr_rp_q;
    logic [PW:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    logic              rd_ok, wr_ok;
    logic [NUM_CH-1:0] elig;
    logic              gnt_found;
    logic [CW-1:0]     gnt_idx;
    logic [CW:0]       cand;
    logic              gnt_we, rd_push, wr_push, r_fire, b_fire;
    logic [CW-1:0]     rd_head, wr_head;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign rd_ok = (!ar_valid_q || mbus_ar_ready) && !rd_cnt_q[PW];
    assign wr_ok = (!aw_valid_q || mbus_aw_ready) && (!w_valid_q || mbus_w_ready) && !wr_cnt_q[PW];

    assign mbus_r_ready = (rd_cnt_q != '0);
    assign mbus_b_ready = (wr_cnt_q != '0);
    assign r_fire       = mbus_r_valid && mbus_r_ready;
    assign b_fire       = mbus_b_valid && mbus_b_ready;
    assign rd_head      = rd_ids_q[rd_rp_q];
    assign wr_head      = wr_ids_q[wr_rp_q];
    assign ch_rd_data   = mbus_r_data;
    assign ch_wr_err    = b_fire && (mbus_b_resp != 2'b00);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign elig[gi]         = ch_req_valid[gi] && (ch_req_we[gi] ? wr_ok : rd_ok);
            assign ch_req_ready[gi] = gnt_found && (gnt_idx == CW'(gi));
            assign ch_rd_valid[gi]  = r_fire && (rd_head == CW'(gi));
            assign ch_wr_done[gi]   = b_fire && (wr_head == CW'(gi));
        end
    endgenerate

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = {1'b0, rr_q} + (CW+1)'(k);
            if (cand >= NCH) cand = cand - NCH;
            if (!gnt_found && elig[cand[CW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[CW-1:0];
            end
        end
        // No acceptance may be signalled while reset is held.
        if (reset) gnt_found = 1'b0;
    end

    assign gnt_we  = ch_req_we[gnt_idx];
    assign rd_push = gnt_found && !gnt_we;
    assign wr_push = gnt_found && gnt_we;

    always_comb begin
        rr_d       = rr_q;
        ar_valid_d = mbus_ar_ready ? 1'b0 : ar_valid_q;
        aw_valid_d = mbus_aw_ready ? 1'b0 : aw_valid_q;
        w_valid_d  = mbus_w_ready  ? 1'b0 : w_valid_q;
        ar_addr_d  = ar_addr_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        perr_d     = perr_q || (mbus_r_valid && !mbus_r_ready) || (mbus_b_valid && !mbus_b_ready);
        if (gnt_found) begin
            rr_d = (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + CW'(1);
        end
        if (rd_push) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = ch_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        end
        if (wr_push) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_addr_d  = ch_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            w_data_d   = ch_req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            w_strb_d   = ch_req_strb[gnt_idx*SW +: SW];
        end
        rd_cnt_d = rd_cnt_q;
        if (rd_push && !r_fire) rd_cnt_d = rd_cnt_q + (PW+1)'(1);
        else if (!rd_push && r_fire) rd_cnt_d = rd_cnt_q - (PW+1)'(1);
        wr_cnt_d = wr_cnt_q;
        if (wr_push && !b_fire) wr_cnt_d = wr_cnt_q + (PW+1)'(1);
        else if (!wr_push && b_fire) wr_cnt_d = wr_cnt_q - (PW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q       <= '0;
            ar_valid_q <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_addr_q  <= '0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            perr_q     <= 1'b0;
            rd_wp_q    <= '0;
            rd_rp_q    <= '0;
            wr_wp_q    <= '0;
            wr_rp_q    <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            rr_q       <= rr_d;
            ar_valid_q <= ar_valid_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_addr_q  <= ar_addr_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            perr_q     <= perr_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            if (rd_push) rd_wp_q <= rd_wp_q + PW'(1);
            if (r_fire)  rd_rp_q <= rd_rp_q + PW'(1);
            if (wr_push) wr_wp_q <= wr_wp_q + PW'(1);
            if (b_fire)  wr_rp_q <= wr_rp_q + PW'(1);
        end
    end

    // Order-FIFO storage carries no reset; validity is defined by the counters alone.
    always_ff @(posedge clk) begin
        if (rd_push) rd_ids_q[rd_wp_q] <= gnt_idx;
        if (wr_push) wr_ids_q[wr_wp_q] <= gnt_idx;
    end

    assign mbus_ar_addr  = ar_addr_q;
    assign mbus_ar_valid = ar_valid_q;
    assign mbus_aw_addr  = aw_addr_q;
    assign mbus_aw_valid = aw_valid_q;
    assign mbus_w_data   = w_data_q;
    assign mbus_w_strb   = w_strb_q;
    assign mbus_w_valid  = w_valid_q;
    assign protocol_err  = perr_q;
endmodule

// File: tb/tb_vfu_mbus_arb.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-based transaction model of the arbiter.
module tb_vfu_mbus_arb;
    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int SW  = DW / 8;
    localparam int OUT = 8;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]    req_valid, req_we, ch_req_ready, ch_rd_valid, ch_wr_done;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_strb;
    logic [DW-1:0]   ch_rd_data, r_data, mbus_w_data;
    logic            ch_wr_err, protocol_err;
    logic [AW-1:0]   mbus_ar_addr, mbus_aw_addr;
    logic            mbus_ar_valid, ar_ready, r_valid, mbus_r_ready;
    logic            mbus_aw_valid, aw_ready, mbus_w_valid, w_ready;
    logic [SW-1:0]   mbus_w_strb;
    logic [1:0]      b_resp;
    logic            b_valid, mbus_b_ready;

    vfu_mbus_arb #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(OUT)) dut (
        .clk(clk), .reset(reset),
        .ch_req_valid(req_valid), .ch_req_ready(ch_req_ready), .ch_req_we(req_we),
        .ch_req_addr(req_addr), .ch_req_wdata(req_wdata), .ch_req_strb(req_strb),
        .ch_rd_valid(ch_rd_valid), .ch_rd_data(ch_rd_data),
        .ch_wr_done(ch_wr_done), .ch_wr_err(ch_wr_err),
        .mbus_ar_addr(mbus_ar_addr), .mbus_ar_valid(mbus_ar_valid), .mbus_ar_ready(ar_ready),
        .mbus_r_data(r_data), .mbus_r_valid(r_valid), .mbus_r_ready(mbus_r_ready),
        .mbus_aw_addr(mbus_aw_addr), .mbus_aw_valid(mbus_aw_valid), .mbus_aw_ready(aw_ready),
        .mbus_w_data(mbus_w_data), .mbus_w_strb(mbus_w_strb), .mbus_w_valid(mbus_w_valid),
        .mbus_w_ready(w_ready),
        .mbus_b_resp(b_resp), .mbus_b_valid(b_valid), .mbus_b_ready(mbus_b_ready),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // Transaction-level model: which requests sit on the bus, and the issue order per direction.
    int            checks = 0;
    int            failures = 0;
    int            rr_m;
    bit            ar_busy_m, aw_busy_m, w_busy_m, perr_m;
    logic [AW-1:0] ar_addr_m, aw_addr_m;
    logic [DW-1:0] w_data_m;
    logic [SW-1:0] w_strb_m;
    int            rdq[$];
    int            wrq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        rr_m = 0; ar_busy_m = 0; aw_busy_m = 0; w_busy_m = 0; perr_m = 0;
        ar_addr_m = '0; aw_addr_m = '0; w_data_m = '0; w_strb_m = '0;
        rdq.delete(); wrq.delete();
    endtask

    task automatic idle();
        req_valid = '0; req_we = '0; ar_ready = 0; aw_ready = 0; w_ready = 0;
        r_valid = 0; b_valid = 0; b_resp = 2'b00; r_data = '0;
    endtask

    task automatic set_req(input int c, input bit we, input logic [AW-1:0] a);
        req_we[c] = we;
        req_addr[c*AW +: AW] = a;
        req_wdata[c*DW +: DW] = {$urandom, $urandom};
        req_strb[c*SW +: SW] = SW'($urandom);
    endtask

    // Reset asserted away from the clock edge; outputs must clear without waiting for one.
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk("rst_req_ready", ch_req_ready, '0);
        chk("rst_ar_valid", mbus_ar_valid, 0);
        chk("rst_aw_valid", mbus_aw_valid, 0);
        chk("rst_w_valid", mbus_w_valid, 0);
        chk("rst_r_ready", mbus_r_ready, 0);
        chk("rst_b_ready", mbus_b_ready, 0);
        chk("rst_rd_valid", ch_rd_valid, '0);
        chk("rst_wr_done", ch_wr_done, '0);
        chk("rst_wr_err", ch_wr_err, 0);
        chk("rst_perr", protocol_err, 0);
        chk("rst_ar_addr", mbus_ar_addr, '0);
        chk("rst_w_data", mbus_w_data, '0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: predict and compare all outputs, then advance the model at the edge.
    task automatic cycle(output int g);
        bit rd_ok, wr_ok, r_fire, b_fire;
        int c;
        logic [N-1:0] rdy_e, rdv_e, wd_e;
        #1;
        r_fire = r_valid && (rdq.size() > 0);
        b_fire = b_valid && (wrq.size() > 0);
        rd_ok = (!ar_busy_m || ar_ready) && (rdq.size() < OUT);
        wr_ok = (!aw_busy_m || aw_ready) && (!w_busy_m || w_ready) && (wrq.size() < OUT);
        g = -1;
        for (int k = 0; k < N; k++) begin
            c = (rr_m + k) % N;
            if (g < 0 && req_valid[c] && (req_we[c] ? wr_ok : rd_ok)) g = c;
        end
        rdy_e = '0; rdv_e = '0; wd_e = '0;
        if (g >= 0) rdy_e[g] = 1'b1;
        if (r_fire) rdv_e[rdq[0]] = 1'b1;
        if (b_fire) wd_e[wrq[0]] = 1'b1;
        chk("req_ready", ch_req_ready, rdy_e);
        chk("ar_valid", mbus_ar_valid, ar_busy_m);
        chk("ar_addr", mbus_ar_addr, ar_addr_m);
        chk("aw_valid", mbus_aw_valid, aw_busy_m);
        chk("aw_addr", mbus_aw_addr, aw_addr_m);
        chk("w_valid", mbus_w_valid, w_busy_m);
        chk("w_data", mbus_w_data, w_data_m);
        chk("w_strb", mbus_w_strb, w_strb_m);
        chk("r_ready", mbus_r_ready, rdq.size() > 0);
        chk("b_ready", mbus_b_ready, wrq.size() > 0);
        chk("rd_valid", ch_rd_valid, rdv_e);
        if (r_fire) chk("rd_data", ch_rd_data, r_data);
        chk("wr_done", ch_wr_done, wd_e);
        chk("wr_err", ch_wr_err, b_fire && (b_resp != 2'b00));
        chk("perr", protocol_err, perr_m);
        @(posedge clk);
        if (r_valid && rdq.size() == 0) perr_m = 1;
        if (b_valid && wrq.size() == 0) perr_m = 1;
        if (r_fire) void'(rdq.pop_front());
        if (b_fire) void'(wrq.pop_front());
        if (ar_ready) ar_busy_m = 0;
        if (aw_ready) aw_busy_m = 0;
        if (w_ready)  w_busy_m = 0;
        if (g >= 0) begin
            rr_m = (g + 1) % N;
            if (req_we[g]) begin
                aw_busy_m = 1; w_busy_m = 1;
                aw_addr_m = req_addr[g*AW +: AW];
                w_data_m  = req_wdata[g*DW +: DW];
                w_strb_m  = req_strb[g*SW +: SW];
                wrq.push_back(g);
            end else begin
                ar_busy_m = 1;
                ar_addr_m = req_addr[g*AW +: AW];
                rdq.push_back(g);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int g;
        idle();
        ar_ready = 1; aw_ready = 1; w_ready = 1;
        for (int i = 0; i < 2 * OUT + 4; i++) begin
            r_valid = rdq.size() > 0; r_data = {$urandom, $urandom};
            b_valid = wrq.size() > 0; b_resp = 2'($urandom);
            cycle(g);
        end
    endtask

    initial begin
        int g;
        idle();
        req_addr = '0; req_wdata = '0; req_strb = '0;
        req_valid = '1;
        apply_reset();
        idle();

        // Round-robin between two reading channels
        set_req(0, 0, 32'h0000_1000);
        set_req(1, 0, 32'h0000_2000);
        req_valid = 3'b011; ar_ready = 1;
        for (int i = 0; i < 8; i++) begin
            r_valid = rdq.size() > 0; r_data = {$urandom, $urandom};
            cycle(g);
            chk("rr_grant", g, i % 2);
        end
        drain();

        // Outstanding-read limit
        apply_reset();
        idle();
        set_req(0, 0, 32'h0000_0040);
        req_valid = 3'b001; ar_ready = 1;
        for (int i = 0; i < 9; i++) begin
            cycle(g);
            chk("lim_grant", g, (i < OUT) ? 0 : -1);
        end
        r_valid = 1; r_data = 64'hDEAD_BEEF_0000_0001;
        cycle(g);
        chk("lim_pop_cycle", g, -1);
        r_valid = 0;
        cycle(g);
        chk("lim_after_pop", g, 0);
        drain();

        // Write with AW accepted at once and W delayed
        apply_reset();
        idle();
        set_req(0, 1, 32'h0000_8000);
        req_valid = 3'b001; aw_ready = 1; w_ready = 0;
        cycle(g);
        chk("wsplit_grant", g, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(g);
            chk("wsplit_wait", g, -1);
        end
        w_ready = 1;
        cycle(g);
        chk("wsplit_regrant", g, 0);
        req_valid = '0;
        cycle(g);
        b_valid = 1; b_resp = 2'b10;
        #1;
        chk("wsplit_done", ch_wr_done, 3'b001);
        chk("wsplit_err", ch_wr_err, 1);
        cycle(g);
        b_resp = 2'b00;
        cycle(g);
        drain();

        // Writes blocked on AW must not hold up reads from another channel
        apply_reset();
        idle();
        set_req(0, 1, 32'h0000_A000);
        set_req(1, 0, 32'h0000_B000);
        req_valid = 3'b011; ar_ready = 1; w_ready = 1;
        cycle(g);
        chk("mix_first", g, 0);
        for (int i = 0; i < 5; i++) begin
            r_valid = rdq.size() > 0; r_data = {$urandom, $urandom};
            cycle(g);
            chk("mix_read", g, 1);
        end
        aw_ready = 1;
        r_valid = rdq.size() > 0;
        cycle(g);
        chk("mix_unstarve", g, 0);
        drain();

        // Stray r beat with nothing outstanding
        apply_reset();
        idle();
        r_valid = 1; r_data = 64'h1234;
        cycle(g);
        r_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(g);
            chk("stray_hold", protocol_err, 1);
        end

        // Randomized mixed traffic
        apply_reset();
        idle();
        for (int i = 0; i < 3000; i++) begin
            req_valid = N'($urandom);
            for (int c = 0; c < N; c++) set_req(c, 1'($urandom), $urandom);
            ar_ready = ($urandom % 10) < 7;
            aw_ready = ($urandom % 10) < 6;
            w_ready  = ($urandom % 10) < 6;
            r_valid  = (rdq.size() > 0) ? (($urandom % 3) != 0) : (($urandom % 400) == 0);
            b_valid  = (wrq.size() > 0) ? (($urandom % 3) != 0) : (($urandom % 400) == 0);
            r_data   = {$urandom, $urandom};
            b_resp   = 2'($urandom);
            cycle(g);
        end

        // Reset with reads still in flight
        apply_reset();
        idle();
        set_req(0, 0, 32'h0000_0100);
        set_req(1, 0, 32'h0000_0200);
        req_valid = 3'b001; ar_ready = 1;
        for (int i = 0; i < 3; i++) cycle(g);
        chk("mid_outstanding", mbus_r_ready, 1);
        req_valid = 3'b011; r_valid = 1; r_data = 64'h55;
        apply_reset();
        cycle(g);
        chk("mid_first_grant", g, 0);
        r_valid = 0;
        cycle(g);
        chk("mid_stray_perr", protocol_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
